// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the load/store sequencer: a request/acknowledge
// handshake with a variable-latency data memory.
interface mem_access_unit_if #(parameter int AW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    // Sequencer side: drives the request, receives data and ack.
    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    // Memory side.
    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the ALU and data memory.
// IDLE -> REQ (hold mem_req until mem_ack) -> RESP (done pulse) -> IDLE.
// Illegal requests skip memory: IDLE -> RESP with addr_err.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN: misaligned half/word accesses
// become errors; without it the low offset bits are truncated.
module mem_access_unit #(
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_valid,
    input  logic [3:0]        ls_op,
    input  logic [AW-1:0]     ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_err,
    mem_access_unit_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Only what the load extraction needs survives past acceptance.
    typedef struct packed {
        logic       uns;
        logic [1:0] size;
        logic [1:0] lane;
    } req_t;

    logic [1:0]  state;
    req_t        req_q;
    logic        err_q;

    logic [1:0]  lane_n;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic        err_n;
    logic [31:0] shifted;
    logic [31:0] ld_ext;

    assign busy     = (state != IDLE);
    assign done     = (state == RESP);
    assign addr_err = done & err_q;

    // Decode the incoming request: effective lane, byte enables, lane-replicated data, legality.
    always_comb begin
        lane_n = ls_addr[1:0];
        be_n   = 4'b0000;
        wd_n   = ls_wdata;
        err_n  = 1'b0;
        case (ls_op[1:0])
            2'b00: begin
                lane_n = ls_addr[1:0];
                be_n   = 4'b0001 << lane_n;
                wd_n   = {4{ls_wdata[7:0]}};
            end
            2'b01: begin
                lane_n = {ls_addr[1], 1'b0};
                be_n   = 4'b0011 << lane_n;
                wd_n   = {2{ls_wdata[15:0]}};
            end
            2'b10: begin
                lane_n = 2'b00;
                be_n   = 4'b1111;
            end
            default: err_n = 1'b1;
        endcase
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        if (ls_op[1:0] == 2'b01 && ls_addr[0])
            err_n = 1'b1;
        if (ls_op[1:0] == 2'b10 && ls_addr[1:0] != 2'b00)
            err_n = 1'b1;
`endif
    end

    // Pick the addressed lane(s) out of the returned word and extend.
    always_comb begin
        shifted = bus.mem_rdata >> {req_q.lane, 3'b000};
        case (req_q.size)
            2'b00:   ld_ext = req_q.uns ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_ext = req_q.uns ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    // Sequencer FSM with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_q         <= '0;
            err_q         <= 1'b0;
            rdata         <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'b0000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ls_valid) begin
                        req_q <= '{uns: ls_op[2], size: ls_op[1:0], lane: lane_n};
                        if (err_n) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else begin
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= ls_op[3];
                            bus.mem_be    <= be_n;
                            bus.mem_addr  <= {ls_addr[AW-1:2], 2'b00};
                            bus.mem_wdata <= wd_n;
                            state         <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_we)
                            rdata <= ld_ext;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.mem_be  <= 4'b0000;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ls_valid;
    logic [3:0]  ls_op;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        busy, done, addr_err;
    logic [31:0] rdata;
    int          checks = 0;
    int          errors = 0;
    int          reqc;

    mem_access_unit_if #(.AW(32)) bus ();

    mem_access_unit #(.AW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ls_valid (ls_valid),
        .ls_op    (ls_op),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .addr_err (addr_err),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the falling edge of cycle 1.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        ls_valid = 1'b1; ls_op = op; ls_addr = a; ls_wdata = wd;
        @(negedge clk);
        ls_valid = 1'b0;
    endtask

    // Hold off ack for 'waits' cycles (checking request stability and
    // poking ls_valid, which must be ignored), then ack with rd.
    // Returns at the falling edge of the done cycle.
    task automatic respond(input int waits, input logic [31:0] rd,
                           input logic [31:0] exp_addr, output int nreq);
        nreq = 0;
        for (int i = 0; i < waits; i++) begin
            if (bus.mem_req) nreq++;
            chk("hold_addr", bus.mem_addr, exp_addr);
            ls_valid = 1'b1; ls_op = 4'b0010; ls_addr = 32'h40;
            @(negedge clk);
        end
        ls_valid = 1'b0;
        if (bus.mem_req) nreq++;
        bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    endtask

    task automatic load(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp, input string tag);
        issue(op, a, 32'h0);
        respond(0, rd, {a[31:2], 2'b00}, reqc);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk(tag, rdata, exp);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; ls_valid = 1'b0; ls_op = 4'h0; ls_addr = 32'h0; ls_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_done",  {31'b0, done}, 32'd0);
        chk("rst_err",   {31'b0, addr_err}, 32'd0);
        chk("rst_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("rst_we",    {31'b0, bus.mem_we}, 32'd0);
        chk("rst_be",    {28'b0, bus.mem_be}, 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // SW 0x104, zero-wait
        issue(4'b1010, 32'h104, 32'hDEADBEEF);
        chk("sw_req",   {31'b0, bus.mem_req}, 32'd1);
        chk("sw_we",    {31'b0, bus.mem_we}, 32'd1);
        chk("sw_addr",  bus.mem_addr, 32'h104);
        chk("sw_be",    {28'b0, bus.mem_be}, 32'hF);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_busy1", {31'b0, busy}, 32'd1);
        chk("sw_done1", {31'b0, done}, 32'd0);
        respond(0, 32'h0, 32'h104, reqc);
        chk("sw_done2", {31'b0, done}, 32'd1);
        chk("sw_err",   {31'b0, addr_err}, 32'd0);
        chk("sw_req2",  {31'b0, bus.mem_req}, 32'd0);
        chk("sw_busy2", {31'b0, busy}, 32'd1);
        chk("sw_rdata", rdata, 32'h0);
        @(negedge clk);
        chk("sw_idle",  {31'b0, busy}, 32'd0);

        // LB 0x203, three wait cycles, ls_valid poked while busy
        issue(4'b0000, 32'h203, 32'h0);
        chk("lb_be",    {28'b0, bus.mem_be}, 32'h8);
        chk("lb_addr",  bus.mem_addr, 32'h200);
        respond(3, 32'h80112233, 32'h200, reqc);
        chk("lb_reqcyc", reqc, 32'd4);
        chk("lb_done",  {31'b0, done}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        @(negedge clk);
        chk("busy_ign_req",  {31'b0, bus.mem_req}, 32'd0);
        chk("busy_ign_busy", {31'b0, busy}, 32'd0);

        // LBU same access
        issue(4'b0100, 32'h203, 32'h0);
        respond(3, 32'h80112233, 32'h200, reqc);
        chk("lbu_rdata", rdata, 32'h00000080);
        @(negedge clk);

        // SH 0x02
        issue(4'b1001, 32'h2, 32'h0000ABCD);
        chk("sh_be",    {28'b0, bus.mem_be}, 32'hC);
        chk("sh_wdata", bus.mem_wdata, 32'hABCDABCD);
        respond(0, 32'h0, 32'h0, reqc);
        chk("sh_rdata_kept", rdata, 32'h00000080);
        @(negedge clk);

        load(4'b0001, 32'h2, 32'h7FFF0000, 32'h00007FFF, "lh_pos");
        load(4'b0001, 32'h0, 32'h1234FFFE, 32'hFFFFFFFE, "lh_neg");
        load(4'b0101, 32'h0, 32'h1234FFFE, 32'h0000FFFE, "lhu");
        load(4'b0000, 32'h1, 32'h0000A500, 32'hFFFFFFA5, "lb_l1");
        load(4'b0110, 32'h8, 32'h87654321, 32'h87654321, "lw_uns");

        // LW 0x06
        issue(4'b0010, 32'h6, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        chk("lwm_done",  {31'b0, done}, 32'd1);
        chk("lwm_err",   {31'b0, addr_err}, 32'd1);
        chk("lwm_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("lwm_rdata", rdata, 32'h87654321);
        @(negedge clk);
`else
        chk("lwm_addr", bus.mem_addr, 32'h4);
        chk("lwm_be",   {28'b0, bus.mem_be}, 32'hF);
        respond(1, 32'h12345678, 32'h4, reqc);
        chk("lwm_done",  {31'b0, done}, 32'd1);
        chk("lwm_err",   {31'b0, addr_err}, 32'd0);
        chk("lwm_rdata", rdata, 32'h12345678);
        @(negedge clk);
`endif

        // Size 11: error without memory access
        issue(4'b0011, 32'h0, 32'h0);
        chk("ill_done", {31'b0, done}, 32'd1);
        chk("ill_err",  {31'b0, addr_err}, 32'd1);
        chk("ill_req",  {31'b0, bus.mem_req}, 32'd0);
        chk("ill_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("ill_done2", {31'b0, done}, 32'd0);
        chk("ill_err2",  {31'b0, addr_err}, 32'd0);

        // Reset in the second wait cycle of a load
        issue(4'b0010, 32'h10, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("rstm_busy",  {31'b0, busy}, 32'd0);
        chk("rstm_rdata", rdata, 32'd0);
        reqc = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) reqc++;
            @(negedge clk);
        end
        chk("rstm_nodone", reqc, 32'd0);
        load(4'b0010, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D, "lw_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
